// File: rtl/snake_pkg.sv
// snake_pkg: shared encodings, grid geometry and reset constants for snake_ctrl.
package snake_pkg;

  typedef enum logic [1:0] {
    OBJ_NONE = 2'b00,
    OBJ_HEAD = 2'b01,
    OBJ_BODY = 2'b10
  } obj_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_MOVE  = 3'd2,
    ST_CHECK = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  // Grid cell: 40 columns fit in 6 bits, 30 rows in 5 bits.
  typedef struct packed {
    logic [5:0] x;
    logic [4:0] y;
  } cell_t;

  localparam int GRID_W = 40;
  localparam int GRID_H = 30;

  localparam logic [5:0] WALL_X_LO = 6'd0;
  localparam logic [5:0] WALL_X_HI = 6'(GRID_W - 1);
  localparam logic [4:0] WALL_Y_LO = 5'd0;
  localparam logic [4:0] WALL_Y_HI = 5'(GRID_H - 1);

  localparam cell_t HEAD_INIT  = '{x: 6'd20, y: 5'd15};
  localparam cell_t SEG1_INIT  = '{x: 6'd19, y: 5'd15};
  localparam cell_t SEG2_INIT  = '{x: 6'd18, y: 5'd15};
  localparam cell_t APPLE_INIT = '{x: 6'd30, y: 5'd10};

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Encoding pairs opposite directions on bit 0, so reversal is a bit flip.
  function automatic dir_e dir_rev(input dir_e d);
    return dir_e'({d[1], ~d[0]});
  endfunction

endpackage

// File: rtl/snake_apple_gen.sv
// snake_apple_gen: free-running 16-bit Fibonacci LFSR folded into the
// playable interior (x 1..38, y 1..28) for apple placement.
module snake_apple_gen
  import snake_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [5:0] next_x,
  output logic [4:0] next_y
);

  logic [15:0] lfsr;
  logic        fb;
  logic [5:0]  rx;
  logic [4:0]  ry;

  // taps 16,14,13,11
  assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // LFSR advances every clock so apple placement depends on play timing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= LFSR_SEED;
    else        lfsr <= {lfsr[14:0], fb};
  end

  // fold raw bits into range without a divider, then skip the wall row/column
  always_comb begin
    rx = lfsr[5:0];
    if (rx >= 6'd38) rx = rx - 6'd32;
    ry = lfsr[12:8];
    if (ry >= 5'd28) ry = ry - 5'd16;
    next_x = rx + 6'd1;
    next_y = ry + 5'd1;
  end

endmodule

// File: rtl/snake_ctrl.sv
// snake_ctrl: snake game state machine, segment list and per-pixel cell lookup.
// Optional SNAKE_SPEEDUP_EN: move period shrinks with score down to TICK_MIN.
module snake_ctrl
  import snake_pkg::*;
#(
  parameter int          MAX_LEN   = 16,
  parameter int          INIT_LEN  = 3,
  parameter int unsigned TICK_DIV  = 12500000,
  parameter int unsigned TICK_STEP = 500000,
  parameter int unsigned TICK_MIN  = 3125000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  output logic [1:0] object,
  output logic [5:0] apple_x,
  output logic [4:0] apple_y,
  output logic       game_over,
  output logic [7:0] score
);

  localparam int            LW       = $clog2(MAX_LEN + 1);
  localparam logic [LW-1:0] LEN_INIT = LW'(INIT_LEN);
  localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);

  state_e              state, state_nx;
  dir_e                dir, pend_dir, key_dir, ref_dir;
  cell_t [MAX_LEN-1:0] seg, seg_init;
  cell_t               apple, head_nx, pix;
  obj_e                obj_q;
  logic [LW-1:0]       len;
  logic [7:0]          score_q;
  logic [31:0]         tick, period;
  logic [MAX_LEN-1:0]  seg_vld, pix_hit, self_hit_v;
  logic [5:0]          gen_x;
  logic [4:0]          gen_y;
  logic                key_vld, restart, tick_done, wall_hit, self_hit, apple_hit, crash;
  logic [5:0]          unused_pix;

  snake_apple_gen u_apple (
    .clk    (clk),
    .rst_n  (rst_n),
    .next_x (gen_x),
    .next_y (gen_y)
  );

  assign pix        = '{x: pixel_x[9:4], y: pixel_y[8:4]};
  assign unused_pix = {pixel_x[3:0], pixel_y[9], ^pixel_y[3:0]};
  assign restart    = (state == ST_OVER) && start;
  assign tick_done  = (state == ST_PLAY) && (tick == period - 32'd1);

  // per-segment compares: live mask, pixel hit and head-vs-body collision
  for (genvar i = 0; i < MAX_LEN; i++) begin : g_seg
    assign seg_vld[i] = (i < int'(len));
    assign pix_hit[i] = seg_vld[i] && (seg[i] == pix);
    if (i == 0) begin : g_head
      assign self_hit_v[i] = 1'b0;
    end else begin : g_body
      assign self_hit_v[i] = seg_vld[i] && (seg[i] == seg[0]);
    end
  end

  assign wall_hit  = (seg[0].x == WALL_X_LO) || (seg[0].x == WALL_X_HI) ||
                     (seg[0].y == WALL_Y_LO) || (seg[0].y == WALL_Y_HI);
  assign self_hit  = |self_hit_v;
  assign crash     = wall_hit || self_hit;
  assign apple_hit = (seg[0] == apple);

  // reset layout of the segment list; tail registers park at (0,0)
  always_comb begin
    seg_init    = '0;
    seg_init[0] = HEAD_INIT;
    seg_init[1] = SEG1_INIT;
    seg_init[2] = SEG2_INIT;
  end

  // next head cell, one step in the direction being latched this MOVE
  always_comb begin
    head_nx = seg[0];
    case (pend_dir)
      DIR_UP:   head_nx.y = seg[0].y - 5'd1;
      DIR_DOWN: head_nx.y = seg[0].y + 5'd1;
      DIR_LEFT: head_nx.x = seg[0].x - 6'd1;
      default:  head_nx.x = seg[0].x + 6'd1;
    endcase
  end

  // key priority up > down > left > right
  always_comb begin
    key_vld = 1'b1;
    key_dir = DIR_RIGHT;
    if      (key_up)    key_dir = DIR_UP;
    else if (key_down)  key_dir = DIR_DOWN;
    else if (key_left)  key_dir = DIR_LEFT;
    else if (key_right) key_dir = DIR_RIGHT;
    else                key_vld = 1'b0;
  end

  // during MOVE, dir is being replaced by pend_dir, so reversal is judged against that
  assign ref_dir = (state == ST_MOVE) ? pend_dir : dir;

  // pending direction register; reversals of the travel direction are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     pend_dir <= DIR_RIGHT;
    else if (restart)                               pend_dir <= DIR_RIGHT;
    else if (key_vld && key_dir != dir_rev(ref_dir)) pend_dir <= key_dir;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // FSM next state
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_PLAY;
      ST_PLAY:  if (tick_done) state_nx = ST_MOVE;
      ST_MOVE:  state_nx = ST_CHECK;
      ST_CHECK: state_nx = crash ? ST_OVER : ST_PLAY;
      ST_OVER:  if (start) state_nx = ST_PLAY;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // game datapath: tick, segment shift, growth/score/apple on eat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg     <= seg_init;
      apple   <= APPLE_INIT;
      dir     <= DIR_RIGHT;
      len     <= LEN_INIT;
      score_q <= '0;
      tick    <= '0;
    end else if (restart) begin
      seg     <= seg_init;
      apple   <= APPLE_INIT;
      dir     <= DIR_RIGHT;
      len     <= LEN_INIT;
      score_q <= '0;
      tick    <= '0;
    end else begin
      if (state == ST_PLAY) tick <= tick_done ? '0 : tick + 32'd1;
      if (state == ST_MOVE) begin
        dir <= pend_dir;
        seg <= {seg[MAX_LEN-2:0], head_nx};
      end
      // growing just widens the live mask: the old tail already sits in seg[len]
      if (state == ST_CHECK && !crash && apple_hit) begin
        if (len != LEN_MAX)    len     <= len + LW'(1);
        if (score_q != 8'hFF)  score_q <= score_q + 8'd1;
        apple <= '{x: gen_x, y: gen_y};
      end
    end
  end

`ifdef SNAKE_SPEEDUP_EN
  logic [31:0] dec, period_calc;

  // max(TICK_DIV - score*TICK_STEP, TICK_MIN) without signed underflow
  always_comb begin
    dec         = 32'(score_q) * TICK_STEP;
    period_calc = (dec >= TICK_DIV - TICK_MIN) ? TICK_MIN : TICK_DIV - dec;
  end

  // period is resampled only when the tick counter wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         period <= TICK_DIV;
    else if (restart)   period <= TICK_DIV;
    else if (tick_done) period <= period_calc;
  end
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = TICK_STEP ^ TICK_MIN;
  assign period     = TICK_DIV;
`endif

  // cell lookup, registered one clock behind pixel_x/pixel_y; head wins over body
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       obj_q <= OBJ_NONE;
    else if (pix_hit[0])              obj_q <= OBJ_HEAD;
    else if (|pix_hit[MAX_LEN-1:1])   obj_q <= OBJ_BODY;
    else                              obj_q <= OBJ_NONE;
  end

  assign object    = obj_q;
  assign apple_x   = apple.x;
  assign apple_y   = apple.y;
  assign game_over = (state == ST_OVER);
  assign score     = score_q;

endmodule

// File: tb/tb_snake_ctrl.sv
// tb_snake_ctrl: directed checks of snake_ctrl with TICK_DIV=8 (10 clk per move).
module tb_snake_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic [9:0] pixel_x = '0, pixel_y = '0;
  logic [1:0] object;
  logic [5:0] apple_x;
  logic [4:0] apple_y;
  logic       game_over;
  logic [7:0] score;

  int checks = 0, failures = 0, cyc = 0, t0 = 0;
  logic [15:0] lfsr_m;

  localparam logic [1:0] NONE = 2'b00, HEAD = 2'b01, BODY = 2'b10;

  snake_ctrl #(
    .MAX_LEN(16), .INIT_LEN(3), .TICK_DIV(8), .TICK_STEP(1), .TICK_MIN(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .object(object),
    .apple_x(apple_x), .apple_y(apple_y), .game_over(game_over), .score(score)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // reference LFSR, stepped alongside the design from the same reset
  always @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr_m <= 16'hACE1;
    else        lfsr_m <= lfsr_step(lfsr_m);

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic int fold_x(input logic [15:0] v);
    int r = int'(v[5:0]);
    if (r >= 38) r -= 32;
    return r + 1;
  endfunction

  function automatic int fold_y(input logic [15:0] v);
    int r = int'(v[12:8]);
    if (r >= 28) r -= 16;
    return r + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    if (cyc > c) chk("sched", cyc, c);
    while (cyc < c) clk1();
  endtask

  // after edge t0+10k: move k has shifted and been checked
  task automatic goto_move(input int k);
    goto(t0 + 10 * k);
  endtask

  task automatic look(input string tag, input int px, input int py, input logic [1:0] exp);
    pixel_x = 10'(px);
    pixel_y = 10'(py);
    clk1();
    chk(tag, object, exp);
  endtask

  task automatic press(input logic u, input logic d, input logic l, input logic r);
    key_up = u; key_down = d; key_left = l; key_right = r;
    clk1();
    key_up = 0; key_down = 0; key_left = 0; key_right = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    clk1();
    start = 1'b0;
    t0 = cyc;
  endtask

  // from a fresh start: right, up, (up+left), up to row 10, right to the apple at (30,10)
  task automatic steer_to_apple();
    logic [15:0] pred;
    goto_move(1);
    look("m1_head", 336, 240, HEAD);
    press(1, 0, 0, 0);
    goto_move(2);
    look("up_head", 336, 224, HEAD);
    look("up_body", 336, 240, BODY);
    press(1, 0, 1, 0);
    goto_move(3);
    look("prio_up_head", 336, 208, HEAD);
    look("prio_no_left", 320, 224, NONE);
    goto_move(6);
    look("row10_head", 336, 160, HEAD);
    press(0, 0, 0, 1);
    goto_move(7);
    look("turn_right", 352, 160, HEAD);
    goto_move(14);
    chk("pre_eat_score", score, 0);
    goto(t0 + 149);
    pred = lfsr_m;
    goto_move(15);
    chk("eat_score", score, 1);
    chk("eat_apple_x", apple_x, fold_x(pred));
    chk("eat_apple_y", apple_y, fold_y(pred));
    chk("eat_no_over", game_over, 0);
    look("eat_head", 480, 160, HEAD);
    look("eat_tail", 432, 160, BODY);
    look("eat_past_tail", 416, 160, NONE);
  endtask

  initial begin
    logic [15:0] v;
    int found, x2, k2;

    // reset state
    repeat (2) clk1();
    chk("rst_object", object, NONE);
    chk("rst_game_over", game_over, 0);
    chk("rst_score", score, 0);
    chk("rst_apple_x", apple_x, 30);
    chk("rst_apple_y", apple_y, 10);
    rst_n = 1'b1;
    look("idle_head", 320, 240, HEAD);
    look("idle_seg1", 304, 240, BODY);
    look("idle_seg2", 293, 250, BODY);
    look("idle_tail_none", 272, 240, NONE);

    // game 1: straight right into the east wall
    do_start();
    goto_move(1);
    look("g1_head", 336, 240, HEAD);
    look("g1_body", 320, 240, BODY);
    look("g1_beyond_len", 288, 240, NONE);
    look("g1_origin", 0, 0, NONE);
    chk("g1_play_over", game_over, 0);
    press(0, 0, 1, 0);
    goto_move(2);
    look("rev_ignored", 352, 240, HEAD);
    goto_move(18);
    chk("x38_no_over", game_over, 0);
    look("x38_head", 608, 240, HEAD);
    goto_move(19);
    chk("wall_over", game_over, 1);
    look("wall_head", 624, 240, HEAD);
    look("wall_body", 608, 240, BODY);
    goto(t0 + 1190);
    chk("frozen_over", game_over, 1);
    look("frozen_head", 624, 240, HEAD);
    look("frozen_seg2", 592, 240, BODY);
    look("frozen_seg3", 576, 240, NONE);
    chk("frozen_score", score, 0);

    // wait in OVER until the second apple is predicted at (31..38, 10)
    found = 0;
    for (int n = 0; n < 5000 && found == 0; n++) begin
      v = lfsr_m;
      for (int s = 0; s < 150; s++) v = lfsr_step(v);
      if (fold_y(v) == 10 && fold_x(v) >= 31) found = 1;
      else clk1();
    end
    chk("apple_search", found, 1);
    x2 = (found != 0) ? fold_x(v) : 31;
    k2 = 15 + x2 - 30;

    // game 2: eat twice, then curl into the body
    do_start();
    chk("g2_restart_over", game_over, 0);
    chk("g2_restart_apple_x", apple_x, 30);
    look("g2_restart_head", 320, 240, HEAD);
    steer_to_apple();
    goto_move(k2);
    chk("eat2_score", score, 2);
    look("eat2_seg4", (x2 - 4) * 16, 160, BODY);
    look("eat2_seg5", (x2 - 5) * 16, 160, NONE);
    press(1, 0, 0, 0);
    goto_move(k2 + 1);
    press(0, 0, 1, 0);
    goto_move(k2 + 2);
    chk("curl_no_over", game_over, 0);
    press(0, 1, 0, 0);
    goto_move(k2 + 3);
    chk("self_over", game_over, 1);
    look("self_head_prio", (x2 - 1) * 16, 160, HEAD);

    // game 3: restart values, then reset in the middle of a move
    do_start();
    chk("g3_score", score, 0);
    chk("g3_over", game_over, 0);
    chk("g3_apple_x", apple_x, 30);
    chk("g3_apple_y", apple_y, 10);
    steer_to_apple();
    pixel_x = 10'd480;
    pixel_y = 10'd160;
    goto(t0 + 158);
    chk("pre_rst_object", object, HEAD);
    rst_n = 1'b0;
    #1;
    chk("mrst_object", object, NONE);
    chk("mrst_game_over", game_over, 0);
    chk("mrst_score", score, 0);
    chk("mrst_apple_x", apple_x, 30);
    chk("mrst_apple_y", apple_y, 10);
    repeat (2) clk1();
    rst_n = 1'b1;
    look("mrst_head", 320, 240, HEAD);
    look("mrst_no_shift", 336, 240, NONE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
